// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Shared types and default sizes for the FIFO round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    localparam int N_PORTS_DEF = 4;
    localparam int AW_DEF      = 32;
    localparam int DW_DEF      = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational circular priority picker starting at ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N_PORTS = 4,
    parameter int IDW     = $clog2(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [N_PORTS-1:0] gnt_onehot,
    output logic [IDW-1:0]     gnt_idx,
    output logic               any
);

    int             w_cand;
    logic [IDW-1:0] w_idx;

    // Walk ptr, ptr+1, ... modulo N_PORTS; the first requester found wins.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        w_cand     = 0;
        w_idx      = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            w_cand = int'(ptr) + i;
            if (w_cand >= N_PORTS) begin
                w_cand = w_cand - N_PORTS;
            end
            w_idx = IDW'(w_cand);
            if (!any && req[w_idx]) begin
                any               = 1'b1;
                gnt_idx           = w_idx;
                gnt_onehot[w_idx] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rr_arbiter
// Description : Pops one upstream FIFO at a time in round-robin order and
//               presents the entry on a valid/ready master port.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rr_arbiter
    import arb_pkg::*;
#(
    parameter int N_PORTS = N_PORTS_DEF,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int IDW     = $clog2(N_PORTS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_PORTS-1:0]    fifo_empty_i,
    input  logic [N_PORTS-1:0]    fifo_write_i,
    input  logic [N_PORTS*AW-1:0] fifo_addr_i,
    input  logic [N_PORTS*DW-1:0] fifo_wdata_i,
    output logic [N_PORTS-1:0]    fifo_pop_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic                  m_write_o,
    output logic [AW-1:0]         m_addr_o,
    output logic [DW-1:0]         m_wdata_o,
    output logic [IDW-1:0]        m_grant_id_o
);

    localparam logic [IDW-1:0] c_LAST_ID = IDW'(N_PORTS - 1);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [IDW-1:0]   r_prio_ptr;
    logic             r_valid;
    logic             r_write;
    logic [AW-1:0]    r_addr;
    logic [DW-1:0]    r_wdata;
    logic [IDW-1:0]   r_grant_id;

    logic [N_PORTS-1:0] w_req;
    logic [N_PORTS-1:0] w_gnt_onehot;
    logic [IDW-1:0]     w_gnt_idx;
    logic               w_any;
    logic               w_grant;
    logic               w_accept;

    logic [AW-1:0] w_addr_arr  [N_PORTS];
    logic [DW-1:0] w_wdata_arr [N_PORTS];

    generate
        for (genvar k = 0; k < N_PORTS; k++) begin : g_unpack
            assign w_addr_arr[k]  = fifo_addr_i[k*AW +: AW];
            assign w_wdata_arr[k] = fifo_wdata_i[k*DW +: DW];
        end
    endgenerate

    assign w_req = ~fifo_empty_i;

    rr_pick #(
        .N_PORTS (N_PORTS),
        .IDW     (IDW)
    ) u_rr_pick (
        .req        (w_req),
        .ptr        (r_prio_ptr),
        .gnt_onehot (w_gnt_onehot),
        .gnt_idx    (w_gnt_idx),
        .any        (w_any)
    );

    assign w_grant  = (r_state == IDLE) && w_any;
    assign w_accept = (r_state == BUSY) && r_valid && m_ready_i;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any)    w_state_nxt = BUSY;
            BUSY:    if (w_accept) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Pop strobe is gated by reset so nothing is consumed while held in reset.
    always_comb begin
        fifo_pop_o = '0;
        if (reset && (r_state == IDLE)) begin
            fifo_pop_o = w_gnt_onehot;
        end
    end

    // Transaction capture and fairness pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prio_ptr <= '0;
            r_valid    <= 1'b0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_grant_id <= '0;
        end else if (w_grant) begin
            r_valid    <= 1'b1;
            r_write    <= fifo_write_i[w_gnt_idx];
            r_addr     <= w_addr_arr[w_gnt_idx];
            r_wdata    <= fifo_write_i[w_gnt_idx] ? w_wdata_arr[w_gnt_idx] : '0;
            r_grant_id <= w_gnt_idx;
        end else if (w_accept) begin
            r_valid    <= 1'b0;
            r_prio_ptr <= (r_grant_id == c_LAST_ID) ? '0 : r_grant_id + 1'b1;
        end
    end

    assign m_valid_o    = r_valid;
    assign m_write_o    = r_write;
    assign m_addr_o     = r_addr;
    assign m_wdata_o    = r_wdata;
    assign m_grant_id_o = r_grant_id;

endmodule
`default_nettype wire

// File: doc/fifo_rr_arbiter.md
Name: fifo_rr_arbiter

Overview:
Round-robin arbiter that sits downstream of the per-slave APB FIFOs and feeds the single interconnect master port.
- Watches the empty flag of each FIFO and pops one entry from the chosen FIFO.
- Registers the popped address, write data and direction, then holds them on a valid/ready master interface until they are accepted.
- Fairness: after each accepted transfer, the granted port drops to lowest priority.

Parameters:
- N_PORTS, 4, number of upstream FIFOs (2..8).
- AW, 32, address width.
- DW, 32, write-data width.
- IDW, $clog2(N_PORTS), width of the grant id.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- fifo_empty_i  in  N_PORTS  per-FIFO empty flag; bit k low means port k is requesting.
- fifo_write_i  in  N_PORTS  per-FIFO direction (1 = write, 0 = read).
- fifo_addr_i  in  N_PORTS*AW  per-FIFO pop address, packed with port k at [k*AW +: AW].
- fifo_wdata_i  in  N_PORTS*DW  per-FIFO pop write data, packed with port k at [k*DW +: DW].
- fifo_pop_o  out  N_PORTS  one-hot pop strobe; at most one bit set.
- m_valid_o  out  1  master-side transaction valid.
- m_ready_i  in  1  master-side accept.
- m_write_o  out  1  latched direction.
- m_addr_o  out  AW  latched address.
- m_wdata_o  out  DW  latched write data; 0 for reads.
- m_grant_id_o  out  IDW  index of the port that owns the current transaction.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, prio_ptr=0.
  - m_valid_o=0, m_write_o=0, m_addr_o=0, m_wdata_o=0, m_grant_id_o=0.
  - fifo_pop_o forced to 0 combinationally while reset is low.
- FSM states: IDLE, BUSY.
- IDLE:
  - req = ~fifo_empty_i.
  - If req==0: stay in IDLE, no pop.
  - Otherwise the winner w is the first set bit of req, scanning circularly from prio_ptr upward (prio_ptr, prio_ptr+1, ... N_PORTS-1, 0, ...).
  - In the same cycle: fifo_pop_o[w]=1 combinationally, and the FIFO data for port w is sampled at the clock edge:
    - m_addr_o <= fifo_addr_i[w]
    - m_write_o <= fifo_write_i[w]
    - m_wdata_o <= fifo_write_i[w] ? fifo_wdata_i[w] : 0
    - m_grant_id_o <= w
    - m_valid_o <= 1
    - state <= BUSY
- BUSY:
  - fifo_pop_o=0.
  - Outputs are held stable while m_valid_o=1 and m_ready_i=0.
  - On m_valid_o & m_ready_i: m_valid_o <= 0, prio_ptr <= (m_grant_id_o==N_PORTS-1) ? 0 : m_grant_id_o+1, state <= IDLE.
- Latency and throughput:
  - Pop in cycle T (IDLE) gives m_valid_o high in T+1.
  - Minimum 2 cycles per transfer, because IDLE always inserts one arbitration cycle.
- Pop strobe:
  - Exactly one cycle per granted transaction; never asserted in BUSY or while reset is low.
  - Never asserted to a port whose fifo_empty_i=1.
- Empty flags changing during BUSY have no effect; arbitration only occurs in IDLE.
- Boundary conditions:
  - Only one requester: it wins regardless of prio_ptr.
  - Wrap-around: prio_ptr wraps from N_PORTS-1 to 0.
  - m_ready_i high in the same cycle m_valid_o rises: the transfer completes at the end of that cycle.
  - m_ready_i while m_valid_o=0: ignored.
- Reset mid-BUSY: the in-flight transaction is discarded. It has already been popped, so it is lost. This is required behaviour; the bench must not expect a replay.

Decomposition:
- Package arb_pkg:
  - arb_state_t enum {IDLE, BUSY}.
  - Default constants N_PORTS_DEF=4, AW_DEF=32, DW_DEF=32.
- Sub-module rr_pick: combinational circular priority picker.
  - Inputs: req[N_PORTS], ptr[IDW].
  - Outputs: gnt_onehot[N_PORTS], gnt_idx[IDW], any.
  - Contains no state.
- The top module holds the FSM, prio_ptr and the output registers.

Test Plan:
- Reset: hold reset low for 3 cycles with all FIFOs non-empty -> fifo_pop_o=0, m_valid_o=0, all outputs 0; after release, first grant goes to port 0.
- All four ports always requesting, m_ready_i tied to 1 -> grant sequence 0,1,2,3,0,1; each pop is one cycle; m_valid_o pulses every 2nd cycle.
- Only port 2 non-empty (write, addr 0x0000_1000, wdata 0xDEAD_BEEF) -> pop[2] pulses once; next cycle m_valid_o=1, m_write_o=1, m_addr_o=0x1000, m_wdata_o=0xDEADBEEF, m_grant_id_o=2.
- Backpressure: m_ready_i=0 for 5 cycles after a grant to port 1 (read, addr 0x44) -> outputs held stable, m_wdata_o=0, no further pops; ready=1 -> next grant scans from port 2.
- Wrap and skip: prio_ptr=3 (after grant to port 2), requesters {0,1} -> port 0 wins, then port 1.
- Reset asserted during BUSY -> m_valid_o drops asynchronously, prio_ptr=0, no pop; after release, normal arbitration resumes from port 0.
